// File: rtl/gpu_host_pkg.sv
// Shared definitions for the Z80 host port arbiter:
// FSM state encoding and default address width.
package gpu_host_pkg;

    localparam int ADDR_BITS_DEF = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_ISSUE = 2'd1,
        RD_ISSUE = 2'd2,
        RD_WAIT  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/z80_host_port_arb_if.sv
// Bridge-side and RAM-side signals of the host port arbiter.
// slave is the arbiter's view, master the environment's view.
interface z80_host_port_arb_if #(
    parameter int ADDR_BITS = 20
);
    logic                 host_wr_ena;
    logic                 host_rd_req;
    logic [ADDR_BITS-1:0] host_addr;
    logic [7:0]           host_wdata;
    logic [7:0]           host_rData;
    logic                 host_rd_rdy;
    logic                 ram_req;
    logic                 ram_gnt;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_addr;
    logic [7:0]           ram_wdata;
    logic [7:0]           ram_rdata;
    logic                 fifo_full;
    logic                 overflow;

    modport slave (
        input  host_wr_ena, host_rd_req, host_addr, host_wdata,
        input  ram_gnt, ram_rdata,
        output host_rData, host_rd_rdy,
        output ram_req, ram_we, ram_addr, ram_wdata,
        output fifo_full, overflow
    );

    modport master (
        output host_wr_ena, host_rd_req, host_addr, host_wdata,
        output ram_gnt, ram_rdata,
        input  host_rData, host_rd_rdy,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        input  fifo_full, overflow
    );
endinterface

// File: rtl/host_wr_fifo.sv
// Small synchronous FIFO holding queued {addr, data} host writes.
// Push and pop in the same cycle are allowed even when full.
module host_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: dout is only consumed while non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/z80_host_port_arb.sv
// Turns Z80 bridge strobes into arbitrated single-cycle RAM
// transactions; writes are buffered, reads serviced in order.
module z80_host_port_arb
    import gpu_host_pkg::*;
#(
    parameter int ADDR_BITS    = ADDR_BITS_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic             GPU_CLK,
    input  logic             reset_n,
    z80_host_port_arb_if.slave bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam int DW = ADDR_BITS + 8;

    arb_state_t           state;
    logic                 wr_q;
    logic                 rd_q;
    logic                 wr_edge;
    logic                 rd_edge;
    logic                 push;
    logic                 pop;
    logic                 rd_set;
    logic                 rd_err;
    logic                 wr_err;
    logic                 rd_pending;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [LW-1:0]        lat;
    logic [DW-1:0]        head;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [CW-1:0]        cnt_nxt;
    logic                 work_nxt;
    logic                 rd_next;

    assign wr_edge  = bus.host_wr_ena & ~wr_q;
    assign rd_edge  = bus.host_rd_req & ~rd_q;
    assign pop      = (state == WR_ISSUE) & bus.ram_gnt & ~empty;
    assign push     = wr_edge & (~full | pop);
    assign wr_err   = wr_edge & ~push;
    assign rd_set   = rd_edge & ~rd_pending & (state != RD_WAIT);
    assign rd_err   = rd_edge & ~rd_set;
    assign cnt_nxt  = count + CW'(push) - CW'(pop);
    assign work_nxt = (cnt_nxt != '0);
    assign rd_next  = rd_pending | rd_set;

    host_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DW)
    ) u_fifo (
        .clk   (GPU_CLK),
        .rst_n (reset_n),
        .push  (push),
        .pop   (pop),
        .din   ({bus.host_addr, bus.host_wdata}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign bus.fifo_full = full;
    assign bus.ram_req   = (state == WR_ISSUE) | (state == RD_ISSUE);
    assign bus.ram_we    = (state == WR_ISSUE);

    always_comb begin
        bus.ram_addr  = '0;
        bus.ram_wdata = '0;
        unique case (1'b1)
            (state == WR_ISSUE): begin
                bus.ram_addr  = head[DW-1:8];
                bus.ram_wdata = head[7:0];
            end
            (state == RD_ISSUE): bus.ram_addr = rd_addr;
            default: ;
        endcase
    end

    always_ff @(posedge GPU_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            wr_q            <= 1'b0;
            rd_q            <= 1'b0;
            rd_pending      <= 1'b0;
            rd_addr         <= '0;
            lat             <= '0;
            bus.host_rData  <= '0;
            bus.host_rd_rdy <= 1'b0;
            bus.overflow    <= 1'b0;
        end else begin
            wr_q            <= bus.host_wr_ena;
            rd_q            <= bus.host_rd_req;
            bus.host_rd_rdy <= 1'b0;
            if (wr_err | rd_err) bus.overflow <= 1'b1;
            if (rd_set) begin
                rd_pending <= 1'b1;
                rd_addr    <= bus.host_addr;
            end
            unique case (state)
                IDLE: begin
                    if (work_nxt)     state <= WR_ISSUE;
                    else if (rd_next) state <= RD_ISSUE;
                end
                WR_ISSUE: begin
                    if (work_nxt)     state <= WR_ISSUE;
                    else if (rd_next) state <= RD_ISSUE;
                    else              state <= IDLE;
                end
                RD_ISSUE: begin
                    if (bus.ram_gnt) begin
                        rd_pending <= 1'b0;
                        lat        <= LW'(READ_LATENCY);
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // lat==1 is the cycle ram_rdata is valid
                    if (lat == LW'(1)) begin
                        bus.host_rData  <= bus.ram_rdata;
                        bus.host_rd_rdy <= 1'b1;
                        state <= work_nxt ? WR_ISSUE : IDLE;
                    end else begin
                        lat <= lat - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_z80_host_port_arb.sv
// Randomized scoreboard bench for z80_host_port_arb with a
// latency-pipelined RAM model and a flat memory reference model.
module tb_z80_host_port_arb;
    localparam int AB = 20;
    localparam int L  = 2;

    typedef struct {
        logic [AB-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    z80_host_port_arb_if #(.ADDR_BITS(AB)) bus ();

    z80_host_port_arb #(
        .ADDR_BITS    (AB),
        .FIFO_DEPTH   (4),
        .READ_LATENCY (L)
    ) dut (
        .GPU_CLK (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #4 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    bit rd_busy = 0;
    bit prev_rdy = 0;
    logic [AB-1:0] pend_addr = '0;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] model_mem [logic [AB-1:0]];
    logic [7:0] ram_mem   [logic [AB-1:0]];

    function automatic logic [7:0] ram_init(input logic [AB-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    function automatic logic [7:0] model_val(input logic [AB-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : ram_init(a);
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got=%0h want=none", nm, act);
    endtask

    // RAM: transactions latched mid-cycle, read data pipelined by L.
    bit         rd_hit = 0;
    logic [7:0] rd_val = '0;
    logic [7:0] rpipe [L];

    always @(negedge clk) begin
        rd_hit = bus.ram_req && bus.ram_gnt && !bus.ram_we;
        rd_val = ram_mem.exists(bus.ram_addr) ?
                 ram_mem[bus.ram_addr] : ram_init(bus.ram_addr);
        if (bus.ram_req && bus.ram_gnt && bus.ram_we)
            ram_mem[bus.ram_addr] = bus.ram_wdata;
    end

    always @(posedge clk) begin
        rpipe[0] <= rd_hit ? rd_val : 8'hEE;
        for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end

    assign bus.ram_rdata = rpipe[L-1];

    // Monitor: pops the scoreboard whenever the DUT presents output.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_req && bus.ram_gnt && bus.ram_we) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    flag("unexpected_ram_write", bus.ram_addr);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check("ram_write_addr", bus.ram_addr, w.a);
                    check("ram_write_data", bus.ram_wdata, w.d);
                end
            end
            if (bus.host_rd_rdy) begin
                rd_seen++;
                rd_busy = 0;
                check("rdy_single_cycle", prev_rdy, 0);
                if (exp_rd.size() == 0)
                    flag("unexpected_rd_rdy", bus.host_rData);
                else
                    check("read_data", bus.host_rData, exp_rd.pop_front());
            end
            prev_rdy = bus.host_rd_rdy;
        end else begin
            prev_rdy = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit w, input bit r,
                         input logic [AB-1:0] a, input logic [7:0] d,
                         input bit w_ok, input bit r_ok);
        bus.host_addr   = a;
        bus.host_wdata  = d;
        bus.host_wr_ena = w;
        bus.host_rd_req = r;
        if (w && w_ok) begin
            model_mem[a] = d;
            exp_wr.push_back('{a: a, d: d});
        end
        if (r && r_ok) begin
            exp_rd.push_back(model_val(a));
            rd_busy   = 1;
            pend_addr = a;
        end
        tick();
    endtask

    task automatic quiet();
        drive(0, 0, '0, '0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_rd.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) flag("drain_timeout", n);
        repeat (4) tick();
    endtask

    task automatic apply_reset();
        rst_n = 0;
        exp_wr.delete();
        exp_rd.delete();
        rd_busy = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_ram_req"},   bus.ram_req, 0);
        check({pfx, "_ram_we"},    bus.ram_we, 0);
        check({pfx, "_ram_addr"},  bus.ram_addr, 0);
        check({pfx, "_ram_wdata"}, bus.ram_wdata, 0);
        check({pfx, "_rData"},     bus.host_rData, 0);
        check({pfx, "_rd_rdy"},    bus.host_rd_rdy, 0);
        check({pfx, "_fifo_full"}, bus.fifo_full, 0);
        check({pfx, "_overflow"},  bus.overflow, 0);
    endtask

    initial begin
        int w0;
        int r0;
        bit pw;
        bit pr;
        bus.host_wr_ena = 0;
        bus.host_rd_req = 0;
        bus.host_addr   = '0;
        bus.host_wdata  = '0;
        bus.ram_gnt     = 0;

        #20;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1;
        tick();

        // single write held two cycles
        bus.ram_gnt = 1;
        w0 = wr_seen;
        bus.host_addr  = 20'h00123;
        bus.host_wdata = 8'h5A;
        bus.host_wr_ena = 1;
        model_mem[20'h00123] = 8'h5A;
        exp_wr.push_back('{a: 20'h00123, d: 8'h5A});
        tick();
        tick();
        quiet();
        drain();
        check("single_write_count", wr_seen - w0, 1);
        check("single_write_ovf", bus.overflow, 0);

        // read after write on consecutive cycles
        r0 = rd_seen;
        drive(1, 0, 20'h00010, 8'hA5, 1, 0);
        drive(0, 1, 20'h00010, 8'h00, 0, 1);
        quiet();
        drain();
        check("raw_read_count", rd_seen - r0, 1);

        // simultaneous write and read edges
        r0 = rd_seen;
        drive(1, 1, 20'h00002, 8'h11, 1, 1);
        quiet();
        drain();
        check("simul_read_count", rd_seen - r0, 1);

        // randomized traffic with random grant
        pw = 0;
        pr = 0;
        for (int c = 0; c < 800; c++) begin
            bit w;
            bit r;
            logic [AB-1:0] a;
            w = !pw && !bus.fifo_full && ($urandom_range(0, 99) < 40);
            r = !pr && !rd_busy && ($urandom_range(0, 99) < 15);
            a = AB'($urandom_range(0, 15));
            if (w && !r && rd_busy && a == pend_addr) a = a ^ 20'h1;
            bus.ram_gnt = ($urandom_range(0, 3) != 0);
            drive(w, r, a, 8'($urandom), 1, 1);
            pw = w;
            pr = r;
        end
        bus.ram_gnt = 1;
        quiet();
        drain();
        check("random_no_overflow", bus.overflow, 0);

        // grant stall: four queued writes fill the FIFO, fifth drops
        bus.ram_gnt = 0;
        w0 = wr_seen;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 20'h00100 + AB'(i), 8'h70 + 8'(i), 1, 0);
            quiet();
        end
        check("stall_fifo_full", bus.fifo_full, 1);
        drive(1, 0, 20'h001FF, 8'hEE, 0, 0);
        quiet();
        check("stall_overflow", bus.overflow, 1);
        repeat (2) tick();
        check("stall_no_writes", wr_seen - w0, 0);
        bus.ram_gnt = 1;
        drain();
        check("stall_write_count", wr_seen - w0, 4);
        check("stall_fifo_drained", bus.fifo_full, 0);

        // second read edge during RD_WAIT is ignored
        apply_reset();
        check("reset_clears_overflow", bus.overflow, 0);
        r0 = rd_seen;
        drive(0, 1, 20'h0002A, 8'h00, 0, 1);
        quiet();
        drive(0, 1, 20'h0002B, 8'h00, 0, 0);
        quiet();
        drain();
        check("double_read_count", rd_seen - r0, 1);
        check("double_read_overflow", bus.overflow, 1);

        // reset asserted while a read is in RD_WAIT
        apply_reset();
        r0 = rd_seen;
        drive(0, 1, 20'h00033, 8'h00, 0, 0);
        quiet();
        #2;
        rst_n = 0;
        #1;
        check_outputs_zero("midread");
        tick();
        tick();
        rst_n = 1;
        repeat (10) tick();
        check("midread_no_rdy", rd_seen - r0, 0);
        check("midread_fifo_empty", bus.fifo_full, 0);
        check("midread_idle", bus.ram_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/z80_host_port_arb.md
Name: z80_host_port_arb

Overview:
- Sits directly downstream of the Z80 bus bridge, between it and the shared GPU RAM host port.
- Converts the bridge's short write strobes and read request into arbitrated single-cycle RAM transactions.
- Buffers writes in a small FIFO so Z80 writes never stall on RAM contention.
- Services reads in order behind queued writes and returns data with a one-cycle ready pulse.

Parameters:
ADDR_BITS, 20, width of host/RAM address
FIFO_DEPTH, 4, write FIFO entries; power of 2, 2..16
READ_LATENCY, 2, cycles from granted RAM read to valid ram_rdata (1..4)

Ports:
GPU_CLK  in  1  system clock (125 MHz)
reset_n  in  1  asynchronous active-low reset
host_wr_ena  in  1  write strobe from bridge; may be high several cycles
host_rd_req  in  1  read request from bridge; level or pulse
host_addr  in  ADDR_BITS  bridge address, sampled on strobe rising edge
host_wdata  in  8  bridge write data, sampled on host_wr_ena rising edge
host_rData  out  8  read data returned to bridge
host_rd_rdy  out  1  one-cycle pulse; host_rData valid in the same cycle
ram_req  out  1  request to RAM arbiter
ram_gnt  in  1  grant; transaction occurs in a cycle with ram_req && ram_gnt
ram_we  out  1  write enable, meaningful only while ram_req
ram_addr  out  ADDR_BITS  RAM address
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data
fifo_full  out  1  write FIFO full, combinational from count
overflow  out  1  sticky error flag; cleared only by reset

Behaviour:
Reset (async, reset_n low):
- All outputs 0; FIFO empty; FSM in IDLE; no read pending; edge-detect registers 0.

Strobe handling:
- Rising edges of host_wr_ena and host_rd_req are detected against a registered copy of each input.
- Only the rising edge acts; a held level is ignored.
- Write edge: {host_addr, host_wdata} enqueued that cycle. If FIFO full: dropped, overflow <= 1.
- Read edge: captures host_addr into rd_addr and sets rd_pending. If rd_pending already set or a read is in flight: ignored, overflow <= 1.
- Simultaneous write and read edges: write enqueued first; read pends behind it.

FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT.
- IDLE: FIFO non-empty -> WR_ISSUE; else rd_pending -> RD_ISSUE.
- WR_ISSUE: ram_req=1, ram_we=1, ram_addr/ram_wdata = FIFO head.
  - On ram_gnt: pop.
  - Then: FIFO still non-empty (after pop and same-cycle push) -> stay; else rd_pending -> RD_ISSUE; else IDLE.
- RD_ISSUE: entered only with FIFO empty. ram_req=1, ram_we=0, ram_addr=rd_addr.
  - On ram_gnt: clear rd_pending, load latency counter with READ_LATENCY, -> RD_WAIT.
- RD_WAIT: ram_req=0. Counter decrements each cycle. When it reaches 0:
  - host_rData <= ram_rdata, host_rd_rdy <= 1 for exactly one cycle.
  - -> WR_ISSUE if FIFO non-empty, else IDLE.
- Reads always observe every write enqueued before the read edge.
- Writes arriving during RD_ISSUE/RD_WAIT queue up and do not delay the in-flight read.

Timing:
- Read grant in cycle N: ram_rdata sampled at end of cycle N+READ_LATENCY; host_rd_rdy high in cycle N+READ_LATENCY+1.
- Minimum read latency (read edge into empty IDLE, ram_gnt tied high): edge registered at cycle 0, RD_ISSUE granted cycle 1, host_rd_rdy at cycle 2+READ_LATENCY.
- Minimum write latency: FIFO push cycle 0, RAM write cycle 1.

Control and FIFO rules:
- ram_req is deasserted for the cycle after each grant only if no further work is queued; back-to-back writes sustain 1 per cycle under constant grant.
- Simultaneous push and pop while full is allowed; count unchanged, no overflow.
- FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- ram_gnt seen without ram_req is ignored.

Decomposition:
- Shared package gpu_host_pkg: FSM state encoding constants and the default ADDR_BITS.
- One sub-module: host_wr_fifo, a synchronous FIFO (push, pop, head data, full, empty, count) with async active-low reset.

Test Plan:
- Single write: host_wr_ena high 2 cycles, addr 0x00123, data 0x5A, ram_gnt=1 -> exactly one cycle with ram_req=1, ram_we=1, ram_addr=0x00123, ram_wdata=0x5A; no overflow.
- Read-after-write ordering: write 0x00010<=0xA5, then read edge on 0x00010 next cycle; RAM model READ_LATENCY=2 -> RAM write precedes RAM read; host_rd_rdy one-cycle pulse with host_rData=0xA5.
- Grant stall: ram_gnt=0 for 10 cycles with 4 writes queued -> fifo_full=1; 5th write dropped, overflow=1; on grant release exactly 4 RAM writes issue in order.
- Simultaneous edges: write 0x00002<=0x11 and read 0x00002 in the same cycle -> write issued first; host_rData=0x11.
- Double read: second host_rd_req edge during RD_WAIT -> ignored; overflow=1; exactly one host_rd_rdy pulse.
- Reset mid-read: reset_n low during RD_WAIT -> all outputs 0 asynchronously; no host_rd_rdy after release; FIFO empty.
